// File: rtl/fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fu_wb_arbiter
// Purpose  : Two-requester writeback arbiter with a small result FIFO per
//            functional unit and alternating grant onto one writeback port.
// Revision : 1.0
// ============================================================================
module fu_wb_arbiter #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req0_valid_i,
    input  logic [TRANS_ID_BITS-1:0] req0_trans_id_i,
    input  logic [XLEN-1:0]          req0_data_i,
    output logic                     req0_ready_o,
    input  logic                     req1_valid_i,
    input  logic [TRANS_ID_BITS-1:0] req1_trans_id_i,
    input  logic [XLEN-1:0]          req1_data_i,
    output logic                     req1_ready_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic                     busy_o
);

    localparam int                c_PW   = $clog2(DEPTH);
    localparam int                c_CW   = $clog2(DEPTH) + 1;
    localparam int                c_EW   = TRANS_ID_BITS + XLEN;
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    logic [1:0]      w_valid;
    logic [1:0]      w_ready;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [1:0]      w_nonempty;
    logic [c_EW-1:0] w_wdata [2];
    logic [c_EW-1:0] w_head  [2];
    logic            w_grant_any;
    logic            w_grant_idx;
    logic            w_wb_fire;
    logic            r_last;

    assign w_valid    = {req1_valid_i, req0_valid_i};
    assign w_wdata[0] = {req0_trans_id_i, req0_data_i};
    assign w_wdata[1] = {req1_trans_id_i, req1_data_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [c_EW-1:0] r_mem [DEPTH];
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;
            logic [c_CW-1:0] r_count;

            assign w_ready[gi]    = (r_count != c_FULL);
            assign w_nonempty[gi] = (r_count != '0);
            assign w_push[gi]     = w_valid[gi] & w_ready[gi] & ~flush_i;
            assign w_head[gi]     = r_mem[r_rptr];

            // Storage is never reset; the count gates every read of it.
            always_ff @(posedge clk_i) begin
                if (w_push[gi]) begin
                    r_mem[r_wptr] <= w_wdata[gi];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else if (flush_i) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wptr <= r_wptr + c_PW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= r_rptr + c_PW'(1);
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + c_CW'(1);
                        2'b01:   r_count <= r_count - c_CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // Under contention the requester that did not win last time is served.
    assign w_grant_any = |w_nonempty;
    assign w_grant_idx = (&w_nonempty) ? ~r_last : w_nonempty[1];
    assign w_wb_fire   = w_grant_any & ~flush_i;
    assign w_pop       = w_wb_fire ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= 1'b1;
        end else if (flush_i) begin
            r_last <= 1'b1;
        end else if (w_wb_fire) begin
            r_last <= w_grant_idx;
        end
    end

    assign wb_valid_o                   = w_wb_fire;
    assign {wb_trans_id_o, wb_data_o}   = w_wb_fire ? w_head[w_grant_idx] : '0;
    assign busy_o                       = |w_nonempty;
    assign req0_ready_o                 = w_ready[0];
    assign req1_ready_o                 = w_ready[1];

endmodule
`default_nettype wire

// File: tb/tb_fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_wb_arbiter
// Purpose  : Vector table, corner sequences and queue-model random test.
// Revision : 1.0
// ============================================================================
module tb_fu_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int TID   = 3;
    localparam int DEPTH = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            req0_valid_i;
    logic [TID-1:0]  req0_trans_id_i;
    logic [XLEN-1:0] req0_data_i;
    logic            req0_ready_o;
    logic            req1_valid_i;
    logic [TID-1:0]  req1_trans_id_i;
    logic [XLEN-1:0] req1_data_i;
    logic            req1_ready_o;
    logic            wb_valid_o;
    logic [TID-1:0]  wb_trans_id_o;
    logic [XLEN-1:0] wb_data_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    fu_wb_arbiter #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req0_valid_i    (req0_valid_i),
        .req0_trans_id_i (req0_trans_id_i),
        .req0_data_i     (req0_data_i),
        .req0_ready_o    (req0_ready_o),
        .req1_valid_i    (req1_valid_i),
        .req1_trans_id_i (req1_trans_id_i),
        .req1_data_i     (req1_data_i),
        .req1_ready_o    (req1_ready_o),
        .wb_valid_o      (wb_valid_o),
        .wb_trans_id_o   (wb_trans_id_o),
        .wb_data_o       (wb_data_o),
        .busy_o          (busy_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per requester plus the last-served index.
    typedef struct packed {
        logic [TID-1:0]  id;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q0[$];
    ent_t            q1[$];
    int              m_last;
    int              m_g;
    bit              m_rdy0, m_rdy1, m_busy, m_v;
    logic [TID-1:0]  m_id;
    logic [XLEN-1:0] m_d;

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_last = 1;
    endtask

    task automatic model_eval();
        m_rdy0 = (q0.size() < DEPTH);
        m_rdy1 = (q1.size() < DEPTH);
        m_busy = (q0.size() != 0) || (q1.size() != 0);
        m_g = -1;
        if (!flush_i) begin
            if (q0.size() != 0 && q1.size() != 0) m_g = (m_last == 0) ? 1 : 0;
            else if (q0.size() != 0)              m_g = 0;
            else if (q1.size() != 0)              m_g = 1;
        end
        m_v  = (m_g >= 0);
        m_id = '0;
        m_d  = '0;
        if (m_g == 0) begin m_id = q0[0].id; m_d = q0[0].data; end
        if (m_g == 1) begin m_id = q1[0].id; m_d = q1[0].data; end
    endtask

    task automatic model_commit();
        if (flush_i) begin
            model_reset();
        end else begin
            if (m_g == 0) void'(q0.pop_front());
            if (m_g == 1) void'(q1.pop_front());
            if (m_g >= 0) m_last = m_g;
            if (req0_valid_i && m_rdy0) q0.push_back({req0_trans_id_i, req0_data_i});
            if (req1_valid_i && m_rdy1) q1.push_back({req1_trans_id_i, req1_data_i});
        end
    endtask

    // Called just after a negedge, with this cycle's inputs already driven.
    task automatic cycle_check(input string tag);
        #1;
        model_eval();
        chk({tag, ".wb_valid"}, 64'(wb_valid_o), 64'(m_v));
        chk({tag, ".wb_id"},    64'(wb_trans_id_o), 64'(m_id));
        chk({tag, ".wb_data"},  wb_data_o, m_d);
        chk({tag, ".busy"},     64'(busy_o), 64'(m_busy));
        chk({tag, ".ready0"},   64'(req0_ready_o), 64'(m_rdy0));
        chk({tag, ".ready1"},   64'(req1_ready_o), 64'(m_rdy1));
        chk({tag, ".proto"},    64'((req0_valid_i & ~req0_ready_o) | (req1_valid_i & ~req1_ready_o)), 64'(0));
        @(posedge clk_i);
        model_commit();
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0;
        req0_valid_i = 1'b0; req0_trans_id_i = '0; req0_data_i = '0;
        req1_valid_i = 1'b0; req1_trans_id_i = '0; req1_data_i = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".wb_valid"}, 64'(wb_valid_o), 64'(0));
        chk({tag, ".wb_id"},    64'(wb_trans_id_o), 64'(0));
        chk({tag, ".wb_data"},  wb_data_o, 64'(0));
        chk({tag, ".busy"},     64'(busy_o), 64'(0));
        chk({tag, ".ready0"},   64'(req0_ready_o), 64'(1));
        chk({tag, ".ready1"},   64'(req1_ready_o), 64'(1));
    endtask

    typedef struct {
        logic            fl;
        logic            v0;
        logic [TID-1:0]  id0;
        logic [XLEN-1:0] d0;
        logic            v1;
        logic [TID-1:0]  id1;
        logic [XLEN-1:0] d1;
        logic            ev;
        logic [TID-1:0]  eid;
        logic [XLEN-1:0] ed;
        logic            eb;
        logic            er0;
        logic            er1;
    } vec_t;

    vec_t tbl[19];

    initial begin
        //          fl v0 id0  d0     v1 id1  d1      ev eid  ed     eb r0 r1
        tbl[0]  = '{0, 1, 3'd1, 64'h10, 1, 3'd2, 64'h20, 0, 3'd0, 64'h0,  0, 1, 1};
        tbl[1]  = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd1, 64'h10, 1, 1, 1};
        tbl[2]  = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd2, 64'h20, 1, 1, 1};
        tbl[3]  = '{0, 1, 3'd7, 64'h70, 1, 3'd4, 64'h44, 0, 3'd0, 64'h0,  0, 1, 1};
        tbl[4]  = '{0, 0, 3'd0, 64'h0,  1, 3'd5, 64'h55, 1, 3'd7, 64'h70, 1, 1, 1};
        tbl[5]  = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd4, 64'h44, 1, 1, 0};
        tbl[6]  = '{0, 0, 3'd0, 64'h0,  1, 3'd6, 64'h66, 1, 3'd5, 64'h55, 1, 1, 1};
        tbl[7]  = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd6, 64'h66, 1, 1, 1};
        tbl[8]  = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  0, 1, 1};
        tbl[9]  = '{0, 1, 3'd1, 64'h11, 1, 3'd2, 64'h22, 0, 3'd0, 64'h0,  0, 1, 1};
        tbl[10] = '{0, 1, 3'd3, 64'h33, 1, 3'd4, 64'h44, 1, 3'd1, 64'h11, 1, 1, 1};
        tbl[11] = '{0, 1, 3'd5, 64'h55, 0, 3'd0, 64'h0,  1, 3'd2, 64'h22, 1, 1, 0};
        tbl[12] = '{0, 0, 3'd0, 64'h0,  1, 3'd6, 64'h66, 1, 3'd3, 64'h33, 1, 0, 1};
        tbl[13] = '{0, 1, 3'd7, 64'h77, 0, 3'd0, 64'h0,  1, 3'd4, 64'h44, 1, 1, 0};
        tbl[14] = '{1, 0, 3'd0, 64'h0,  1, 3'd1, 64'h01, 0, 3'd0, 64'h0,  1, 0, 1};
        tbl[15] = '{0, 1, 3'd2, 64'h02, 1, 3'd3, 64'h03, 0, 3'd0, 64'h0,  0, 1, 1};
        tbl[16] = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd2, 64'h02, 1, 1, 1};
        tbl[17] = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  1, 3'd3, 64'h03, 1, 1, 1};
        tbl[18] = '{0, 0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  0, 3'd0, 64'h0,  0, 1, 1};

        rst_ni = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1 chk_reset_outputs("in_reset");
        rst_ni = 1'b1;

        // Directed vector table: single push, contention, full+wrap, flush.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            flush_i         = tbl[i].fl;
            req0_valid_i    = tbl[i].v0;
            req0_trans_id_i = tbl[i].id0;
            req0_data_i     = tbl[i].d0;
            req1_valid_i    = tbl[i].v1;
            req1_trans_id_i = tbl[i].id1;
            req1_data_i     = tbl[i].d1;
            #1;
            model_eval();
            chk($sformatf("row%0d.wb_valid", i), 64'(wb_valid_o), 64'(tbl[i].ev));
            chk($sformatf("row%0d.wb_id", i),    64'(wb_trans_id_o), 64'(tbl[i].eid));
            chk($sformatf("row%0d.wb_data", i),  wb_data_o, tbl[i].ed);
            chk($sformatf("row%0d.busy", i),     64'(busy_o), 64'(tbl[i].eb));
            chk($sformatf("row%0d.ready0", i),   64'(req0_ready_o), 64'(tbl[i].er0));
            chk($sformatf("row%0d.ready1", i),   64'(req1_ready_o), 64'(tbl[i].er1));
            @(posedge clk_i);
            model_commit();
        end

        // Fairness: both requesters offer a result whenever they have room.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            idle_inputs();
            req0_valid_i    = (q0.size() < DEPTH);
            req0_trans_id_i = TID'(i);
            req0_data_i     = 64'h1000 + 64'(i);
            req1_valid_i    = (q1.size() < DEPTH);
            req1_trans_id_i = TID'(7 - i);
            req1_data_i     = 64'h2000 + 64'(i);
            cycle_check($sformatf("fair%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            idle_inputs();
            cycle_check($sformatf("drain%0d", i));
        end

        // Asynchronous reset while busy, between clock edges.
        @(negedge clk_i);
        idle_inputs();
        req0_valid_i = 1'b1; req0_trans_id_i = 3'd5; req0_data_i = 64'hABCD;
        req1_valid_i = 1'b1; req1_trans_id_i = 3'd6; req1_data_i = 64'hDCBA;
        cycle_check("pre_areset");
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("pre_areset.busy", 64'(busy_o), 64'(1));
        #1 rst_ni = 1'b0;
        #1 chk_reset_outputs("areset_now");
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        #1 chk_reset_outputs("areset_hold");
        rst_ni = 1'b1;

        // Randomised traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            flush_i         = ($urandom_range(0, 19) == 0);
            req0_valid_i    = (q0.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            req0_trans_id_i = TID'($urandom_range(0, 7));
            req0_data_i     = {$urandom(), $urandom()};
            req1_valid_i    = (q1.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            req1_trans_id_i = TID'($urandom_range(0, 7));
            req1_data_i     = {$urandom(), $urandom()};
            cycle_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, writeback data width.
REQ-002 Parameter TRANS_ID_BITS, default 3, scoreboard transaction-ID width.
REQ-003 Parameter DEPTH, default 2, per-requester buffer entries; power of two, minimum 2.
REQ-004 clk_i  input  1  the one clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 flush_i  input  1  synchronous flush of all buffered results.
REQ-007 req0_valid_i  input  1  requester 0 (MAC8 FU) result valid.
REQ-008 req0_trans_id_i  input  TRANS_ID_BITS  requester 0 scoreboard ID.
REQ-009 req0_data_i  input  XLEN  requester 0 result data.
REQ-010 req0_ready_o  output  1  requester 0 buffer can accept an entry.
REQ-011 req1_valid_i, req1_trans_id_i, req1_data_i, req1_ready_o: same as REQ-007 to REQ-010, for requester 1 (multiplier).
REQ-012 wb_valid_o  output  1  shared writeback port valid to scoreboard.
REQ-013 wb_trans_id_o  output  TRANS_ID_BITS  writeback ID.
REQ-014 wb_data_o  output  XLEN  writeback data.
REQ-015 busy_o  output  1  at least one buffer is non-empty.

Function
REQ-016 Each requester SHALL own a circular FIFO of DEPTH entries, holding {trans_id, data}.
- Read and write pointers: $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
- Count: $clog2(DEPTH)+1 bits.
REQ-017 reqN_ready_o SHALL equal (countN != DEPTH).
- Driven from registered count only.
- Independent of a pop in the same cycle and of flush_i.
REQ-018 Push on reqN_valid_i & reqN_ready_o & !flush_i.
- Data is written at the write pointer.
- The write pointer and count increment on the same edge.
REQ-019 reqN_valid_i while reqN_ready_o=0 SHALL be ignored; the bench SHALL flag it as a protocol error.
REQ-020 The write side is registered: an entry pushed at edge N is visible on wb_* in the cycle after edge N, at the earliest.
REQ-021 Arbitration is combinational over the FIFO heads:
- Only one FIFO non-empty: that FIFO is granted.
- Both non-empty: grant the requester that is not last_q.
- Both empty: no grant.
REQ-022 last_q (1 bit) SHALL load the granted index on every edge at which a grant occurs.
REQ-023 wb_valid_o = grant_exists & !flush_i. wb_trans_id_o and wb_data_o come from the granted head.
REQ-024 wb_trans_id_o and wb_data_o SHALL be all zero when wb_valid_o=0.
REQ-025 The downstream port has no backpressure: every cycle with wb_valid_o=1 pops the granted FIFO.
- Read pointer increments and count decrements at the following edge.
REQ-026 Push and pop on the same FIFO in the same cycle leave its count unchanged; both pointers advance.
REQ-027 Throughput: one writeback per cycle. Under contention the grants alternate strictly.
REQ-028 flush_i=1 at an edge:
- Both counts and all pointers clear to 0.
- last_q loads 1.
- Pushes in that cycle are dropped.
- wb_valid_o is 0 during that cycle.
REQ-029 busy_o = (count0 != 0) | (count1 != 0), from registered state.

Reset
REQ-030 rst_ni=0 SHALL immediately, without waiting for a clock edge:
- clear both counts and all pointers;
- set last_q to 1, so requester 0 wins the first contested grant.
REQ-031 During and after reset: wb_valid_o=0, wb_trans_id_o=0, wb_data_o=0, busy_o=0, req0_ready_o=1, req1_ready_o=1.
REQ-032 FIFO data storage needs no reset. Stale entries SHALL never appear on wb_* outputs.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries, with the REQ-031 output values at once.

Verification
REQ-034 Single push: req0 pushes {id 3, data 0xAA} at edge 1 -> cycle after edge 1: wb_valid_o=1, wb_trans_id_o=3, wb_data_o=0xAA -> cycle after edge 2: wb_valid_o=0, busy_o=0.
REQ-035 Contention: req0 pushes {1, 0x10} and req1 pushes {2, 0x20} at the same edge after reset -> writebacks in order ID 1 then ID 2, in consecutive cycles.
REQ-036 Fairness: both requesters push every cycle for 8 cycles with DEPTH=2 -> grants alternate 0,1,0,1...; each reqN_ready_o drops to 0 when its count reaches 2; no entry is lost or duplicated.
REQ-037 Full plus wrap: fill req1 with IDs 4 and 5, then pop and push ID 6 in the same cycle -> req1_ready_o stays 0 while count is 2; output order is 4, 5, 6 as the pointers wrap.
REQ-038 Flush: both FIFOs hold 2 entries, flush_i=1 for one cycle -> wb_valid_o=0 that cycle; next cycle busy_o=0 and both ready=1; the next contested grant goes to req0.
REQ-039 Async reset: rst_ni pulsed low between clock edges while busy_o=1 -> outputs take the REQ-031 values before the next edge.
